// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and trap sequencer for the 5-stage RV32I pipeline.
// It drives stall, flush and bubble controls to the PC, IF_ID and ID_EX registers.
// It resolves load-use hazards that forwarding in ID cannot cover.
// It redirects the PC on taken branches and jumps resolved in EX.
// It sequences ecall / ebreak / illegal-instruction traps and mret as
// IDLE -> DRAIN -> CSR -> JUMP -> IDLE.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_*                      instruction in ID: valid, pc, sources, exception flags
//   ex_*                      instruction in EX: load/rd info, redirect request and target
//   mem_busy_i                data memory not ready; freezes the whole pipe
//   csr_mtvec_i / csr_mepc_i  trap vector and mret return address
//   stall_*/flush/bubble      pipeline register controls
//   redirect_o/_pc_o          PC load strobe and value
//   csr_trap_we_o, csr_mepc_wdata_o, csr_mcause_o, csr_mret_o   CSR trap-state updates
//   trap_busy_o               sequencer is not idle
module pipe_ctrl #(
  parameter int PC_WIDTH      = 32,
  parameter int REG_IDX_WIDTH = 5,
  parameter int DRAIN_CYCLES  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid_i,
  input  logic [PC_WIDTH-1:0]      id_pc_i,
  input  logic [REG_IDX_WIDTH-1:0] id_rs1_idx_i,
  input  logic [REG_IDX_WIDTH-1:0] id_rs2_idx_i,
  input  logic                     id_rs1_en_i,
  input  logic                     id_rs2_en_i,
  input  logic                     id_excp_ilegl_instr_i,
  input  logic                     id_excp_ecall_i,
  input  logic                     id_excp_ebreak_i,
  input  logic                     id_excp_mret_i,
  input  logic                     ex_is_load_i,
  input  logic                     ex_rd_en_i,
  input  logic [REG_IDX_WIDTH-1:0] ex_rd_idx_i,
  input  logic                     ex_redirect_i,
  input  logic [PC_WIDTH-1:0]      ex_redirect_pc_i,
  input  logic                     mem_busy_i,
  input  logic [PC_WIDTH-1:0]      csr_mtvec_i,
  input  logic [PC_WIDTH-1:0]      csr_mepc_i,
  output logic                     stall_pc_o,
  output logic                     stall_if_id_o,
  output logic                     flush_if_id_o,
  output logic                     bubble_id_ex_o,
  output logic                     stall_all_o,
  output logic                     redirect_o,
  output logic [PC_WIDTH-1:0]      redirect_pc_o,
  output logic                     csr_trap_we_o,
  output logic [PC_WIDTH-1:0]      csr_mepc_wdata_o,
  output logic [3:0]               csr_mcause_o,
  output logic                     csr_mret_o,
  output logic                     trap_busy_o
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, CSR, JUMP} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [PC_WIDTH-1:0] epc;
  logic [3:0]          cause, cause_nxt;
  logic                is_mret, is_mret_nxt;
  logic                id_excp, take_trap, load_use;

  assign id_excp = id_excp_ilegl_instr_i | id_excp_ecall_i | id_excp_ebreak_i | id_excp_mret_i;
  // An EX redirect squashes the instruction in ID, so its exception never fires.
  assign take_trap = id_valid_i & id_excp & ~ex_redirect_i;

  assign load_use = id_valid_i & ex_is_load_i & ex_rd_en_i & (ex_rd_idx_i != '0) &
                    ((id_rs1_en_i & (id_rs1_idx_i == ex_rd_idx_i)) |
                     (id_rs2_en_i & (id_rs2_idx_i == ex_rd_idx_i)));

  // Cause priority: illegal > ecall > ebreak; mret carries cause 0.
  always_comb begin
    cause_nxt   = 4'd0;
    is_mret_nxt = 1'b0;
    if (id_excp_ilegl_instr_i) cause_nxt = 4'd2;
    else if (id_excp_ecall_i)  cause_nxt = 4'd11;
    else if (id_excp_ebreak_i) cause_nxt = 4'd3;
    else                       is_mret_nxt = 1'b1;
  end

  // State register, drain counter and trap latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      epc     <= '0;
      cause   <= '0;
      is_mret <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!mem_busy_i && state == IDLE && take_trap) begin
        epc     <= id_pc_i;
        cause   <= cause_nxt;
        is_mret <= is_mret_nxt;
      end
    end
  end

  // Next-state logic. A busy memory freezes state and counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!mem_busy_i) begin
      case (state)
        IDLE: if (take_trap) begin
          state_nxt = DRAIN;
          cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
        end
        DRAIN: if (cnt == '0) state_nxt = CSR;
               else           cnt_nxt   = cnt - 1'b1;
        CSR:     state_nxt = JUMP;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic. Reset forces every output low in the same cycle.
  always_comb begin
    stall_pc_o       = 1'b0;
    stall_if_id_o    = 1'b0;
    flush_if_id_o    = 1'b0;
    bubble_id_ex_o   = 1'b0;
    stall_all_o      = 1'b0;
    redirect_o       = 1'b0;
    redirect_pc_o    = '0;
    csr_trap_we_o    = 1'b0;
    csr_mepc_wdata_o = '0;
    csr_mcause_o     = '0;
    csr_mret_o       = 1'b0;
    trap_busy_o      = 1'b0;
    if (!rst) begin
      if (mem_busy_i) begin
        stall_all_o   = 1'b1;
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
      end else begin
        trap_busy_o      = (state != IDLE);
        csr_mepc_wdata_o = epc;
        csr_mcause_o     = cause;
        case (state)
          IDLE: begin
            if (ex_redirect_i) begin
              redirect_o     = 1'b1;
              redirect_pc_o  = ex_redirect_pc_i;
              flush_if_id_o  = 1'b1;
              bubble_id_ex_o = 1'b1;
            end else if (take_trap) begin
              flush_if_id_o  = 1'b1;
              bubble_id_ex_o = 1'b1;
              stall_pc_o     = 1'b1;
            end else if (load_use) begin
              stall_pc_o     = 1'b1;
              stall_if_id_o  = 1'b1;
              bubble_id_ex_o = 1'b1;
            end
          end
          DRAIN: begin
            stall_pc_o    = 1'b1;
            flush_if_id_o = 1'b1;
          end
          CSR: begin
            csr_trap_we_o = ~is_mret;
            csr_mret_o    = is_mret;
            stall_pc_o    = 1'b1;
            flush_if_id_o = 1'b1;
          end
          default: begin
            redirect_o    = 1'b1;
            redirect_pc_o = is_mret ? csr_mepc_i : csr_mtvec_i;
            flush_if_id_o = 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl.
// A trap is modelled as a timeline: t counts the non-busy cycles since trap entry.
// Cycles t=1..D drain, t=D+1 writes the CSRs and t=D+2 jumps.
module tb_pipe_ctrl;
  localparam int PW = 32, RW = 5, D = 3;

  logic clk = 1'b0, rst;
  logic id_valid_i, id_rs1_en_i, id_rs2_en_i;
  logic id_excp_ilegl_instr_i, id_excp_ecall_i, id_excp_ebreak_i, id_excp_mret_i;
  logic [PW-1:0] id_pc_i, ex_redirect_pc_i, csr_mtvec_i, csr_mepc_i;
  logic [RW-1:0] id_rs1_idx_i, id_rs2_idx_i, ex_rd_idx_i;
  logic ex_is_load_i, ex_rd_en_i, ex_redirect_i, mem_busy_i;
  logic stall_pc_o, stall_if_id_o, flush_if_id_o, bubble_id_ex_o, stall_all_o;
  logic redirect_o, csr_trap_we_o, csr_mret_o, trap_busy_o;
  logic [PW-1:0] redirect_pc_o, csr_mepc_wdata_o;
  logic [3:0] csr_mcause_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.PC_WIDTH(PW), .REG_IDX_WIDTH(RW), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i),
    .id_rs1_en_i(id_rs1_en_i), .id_rs2_en_i(id_rs2_en_i),
    .id_excp_ilegl_instr_i(id_excp_ilegl_instr_i), .id_excp_ecall_i(id_excp_ecall_i),
    .id_excp_ebreak_i(id_excp_ebreak_i), .id_excp_mret_i(id_excp_mret_i),
    .ex_is_load_i(ex_is_load_i), .ex_rd_en_i(ex_rd_en_i), .ex_rd_idx_i(ex_rd_idx_i),
    .ex_redirect_i(ex_redirect_i), .ex_redirect_pc_i(ex_redirect_pc_i),
    .mem_busy_i(mem_busy_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o), .flush_if_id_o(flush_if_id_o),
    .bubble_id_ex_o(bubble_id_ex_o), .stall_all_o(stall_all_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .csr_trap_we_o(csr_trap_we_o), .csr_mepc_wdata_o(csr_mepc_wdata_o),
    .csr_mcause_o(csr_mcause_o), .csr_mret_o(csr_mret_o), .trap_busy_o(trap_busy_o)
  );

  int n_vec = 0, n_bad = 0;

  // reference model state
  bit            m_active = 0;
  int            m_t = 0;
  logic [PW-1:0] m_epc = '0;
  logic [3:0]    m_cause = '0;
  bit            m_mret = 0;

  // event recorder for directed scenarios
  int            cyc, red_cyc, we_cyc, mret_cyc;
  logic [PW-1:0] red_pc, we_epc;
  logic [3:0]    we_cause;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    assert (act === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle_in();
    id_valid_i = 0; id_pc_i = '0; id_rs1_en_i = 0; id_rs2_en_i = 0;
    id_rs1_idx_i = '0; id_rs2_idx_i = '0;
    id_excp_ilegl_instr_i = 0; id_excp_ecall_i = 0; id_excp_ebreak_i = 0; id_excp_mret_i = 0;
    ex_is_load_i = 0; ex_rd_en_i = 0; ex_rd_idx_i = '0;
    ex_redirect_i = 0; ex_redirect_pc_i = '0; mem_busy_i = 0;
  endtask

  task automatic mark();
    cyc = 0; red_cyc = -1; we_cyc = -1; mret_cyc = -1;
    red_pc = '0; we_epc = '0; we_cause = '0;
  endtask

  // Called at a negedge with inputs applied: check against the model, then advance one clock.
  task automatic tick();
    logic e_spc, e_sif, e_fl, e_bub, e_sall, e_red, e_we, e_mret, e_busy;
    logic [PW-1:0] e_rpc, e_epc;
    logic [3:0] e_cause;
    logic excp, lu;
    int cause_in;
    {e_spc, e_sif, e_fl, e_bub, e_sall, e_red, e_we, e_mret, e_busy} = '0;
    e_rpc = '0; e_epc = '0; e_cause = '0;
    #1;
    excp = id_excp_ilegl_instr_i | id_excp_ecall_i | id_excp_ebreak_i | id_excp_mret_i;
    lu = id_valid_i && ex_is_load_i && ex_rd_en_i && ex_rd_idx_i != 0 &&
         ((id_rs1_en_i && id_rs1_idx_i == ex_rd_idx_i) || (id_rs2_en_i && id_rs2_idx_i == ex_rd_idx_i));
    if (rst) begin
    end else if (mem_busy_i) begin
      e_sall = 1; e_spc = 1; e_sif = 1;
    end else begin
      e_epc = m_epc; e_cause = m_cause; e_busy = m_active;
      if (!m_active) begin
        if (ex_redirect_i) begin e_red = 1; e_rpc = ex_redirect_pc_i; e_fl = 1; e_bub = 1; end
        else if (id_valid_i && excp) begin e_fl = 1; e_bub = 1; e_spc = 1; end
        else if (lu) begin e_spc = 1; e_sif = 1; e_bub = 1; end
      end else begin
        e_fl = 1;
        if (m_t <= D + 1) e_spc = 1;
        if (m_t == D + 1) begin e_we = !m_mret; e_mret = m_mret; end
        if (m_t == D + 2) begin e_red = 1; e_rpc = m_mret ? csr_mepc_i : csr_mtvec_i; end
      end
    end
    chk("ctl_flags",
        64'({stall_pc_o, stall_if_id_o, flush_if_id_o, bubble_id_ex_o, stall_all_o,
             redirect_o, csr_trap_we_o, csr_mret_o, trap_busy_o}),
        64'({e_spc, e_sif, e_fl, e_bub, e_sall, e_red, e_we, e_mret, e_busy}));
    chk("redirect_pc", 64'(redirect_pc_o), 64'(e_rpc));
    chk("mepc_wdata", 64'(csr_mepc_wdata_o), 64'(e_epc));
    chk("mcause", 64'(csr_mcause_o), 64'(e_cause));
    if (redirect_o && red_cyc < 0) begin red_cyc = cyc; red_pc = redirect_pc_o; end
    if (csr_trap_we_o && we_cyc < 0) begin we_cyc = cyc; we_epc = csr_mepc_wdata_o; we_cause = csr_mcause_o; end
    if (csr_mret_o && mret_cyc < 0) mret_cyc = cyc;
    cyc++;
    @(posedge clk);
    if (rst) begin
      m_active = 0; m_t = 0; m_epc = '0; m_cause = '0; m_mret = 0;
    end else if (!mem_busy_i) begin
      if (!m_active) begin
        if (!ex_redirect_i && id_valid_i && excp) begin
          cause_in = id_excp_ilegl_instr_i ? 2 : id_excp_ecall_i ? 11 : id_excp_ebreak_i ? 3 : 0;
          m_active = 1; m_t = 1; m_epc = id_pc_i;
          m_cause = 4'(cause_in); m_mret = (cause_in == 0);
        end
      end else begin
        m_t++;
        if (m_t > D + 2) m_active = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1; idle_in(); csr_mtvec_i = '0; csr_mepc_i = '0; mark();
    @(negedge clk);
    tick();
    // reset must mask even active requests
    ex_redirect_i = 1; ex_redirect_pc_i = 32'h80; id_valid_i = 1; id_excp_ecall_i = 1; mem_busy_i = 1;
    #1 chk("rst_masks_out", 64'({stall_pc_o, stall_all_o, redirect_o, flush_if_id_o, trap_busy_o}), 64'(0));
    tick();
    rst = 0; idle_in();
    tick();

    // load-use: one cycle of stall, then clear once the load leaves EX
    ex_is_load_i = 1; ex_rd_en_i = 1; ex_rd_idx_i = 5;
    id_valid_i = 1; id_rs1_en_i = 1; id_rs1_idx_i = 5;
    #1 chk("load_use_stall", 64'({stall_pc_o, stall_if_id_o, bubble_id_ex_o}), 64'(3'b111));
    tick();
    ex_is_load_i = 0;
    #1 chk("load_use_clear", 64'({stall_pc_o, stall_if_id_o, bubble_id_ex_o}), 64'(0));
    tick();
    ex_is_load_i = 1; ex_rd_idx_i = 0; id_rs1_idx_i = 0;
    #1 chk("load_use_x0", 64'({stall_pc_o, stall_if_id_o, bubble_id_ex_o}), 64'(0));
    tick();
    idle_in();

    // EX redirect wins over ecall in ID
    ex_redirect_i = 1; ex_redirect_pc_i = 32'h80; id_valid_i = 1; id_excp_ecall_i = 1; id_pc_i = 32'h90;
    #1 chk("redir_pc", 64'(redirect_pc_o), 64'h80);
    chk("redir_flush", 64'({redirect_o, flush_if_id_o, bubble_id_ex_o}), 64'(3'b111));
    tick();
    idle_in();
    #1 chk("redir_no_trap", 64'(trap_busy_o), 64'(0));
    tick();

    // ecall trap
    csr_mtvec_i = 32'h100; csr_mepc_i = 32'h44;
    id_valid_i = 1; id_excp_ecall_i = 1; id_pc_i = 32'h40; mark();
    tick(); idle_in(); repeat (6) tick();
    chk("ecall_we_cyc", 64'(we_cyc), 64'(4));
    chk("ecall_mepc", 64'(we_epc), 64'h40);
    chk("ecall_cause", 64'(we_cause), 64'd11);
    chk("ecall_red_cyc", 64'(red_cyc), 64'(5));
    chk("ecall_red_pc", 64'(red_pc), 64'h100);

    // mret
    id_valid_i = 1; id_excp_mret_i = 1; id_pc_i = 32'h48; mark();
    tick(); idle_in(); repeat (6) tick();
    chk("mret_cyc", 64'(mret_cyc), 64'(4));
    chk("mret_no_we", 64'(we_cyc), 64'(-1));
    chk("mret_red_pc", 64'(red_pc), 64'h44);

    // illegal + ebreak together
    id_valid_i = 1; id_excp_ilegl_instr_i = 1; id_excp_ebreak_i = 1; id_pc_i = 32'h50; mark();
    tick(); idle_in(); repeat (6) tick();
    chk("ill_cause", 64'(we_cause), 64'd2);
    chk("ill_mepc", 64'(we_epc), 64'h50);

    // mem_busy during DRAIN delays the redirect by exactly its length
    id_valid_i = 1; id_excp_ebreak_i = 1; id_pc_i = 32'h60; mark();
    tick(); idle_in(); tick(); tick();
    mem_busy_i = 1; tick(); tick(); mem_busy_i = 0;
    repeat (5) tick();
    chk("busy_we_cyc", 64'(we_cyc), 64'(6));
    chk("busy_red_cyc", 64'(red_cyc), 64'(7));

    // reset while in CSR
    id_valid_i = 1; id_excp_ecall_i = 1; id_pc_i = 32'h70; mark();
    tick(); idle_in(); repeat (3) tick();
    rst = 1; tick(); rst = 0; tick(); tick();
    chk("rst_csr_no_we", 64'(we_cyc), 64'(-1));
    chk("rst_csr_no_red", 64'(red_cyc), 64'(-1));
    #1 chk("rst_csr_idle", 64'(trap_busy_o), 64'(0));
    tick();

    // randomized traffic against the model
    repeat (600) begin
      rst = ($urandom_range(0, 99) == 0);
      id_valid_i = ($urandom_range(0, 3) != 0);
      id_pc_i = $urandom;
      id_rs1_en_i = $urandom_range(0, 1); id_rs2_en_i = $urandom_range(0, 1);
      id_rs1_idx_i = RW'($urandom_range(0, 3)); id_rs2_idx_i = RW'($urandom_range(0, 3));
      id_excp_ilegl_instr_i = ($urandom_range(0, 19) == 0);
      id_excp_ecall_i = ($urandom_range(0, 19) == 0);
      id_excp_ebreak_i = ($urandom_range(0, 19) == 0);
      id_excp_mret_i = ($urandom_range(0, 19) == 0);
      ex_is_load_i = $urandom_range(0, 1); ex_rd_en_i = ($urandom_range(0, 3) != 0);
      ex_rd_idx_i = RW'($urandom_range(0, 3));
      ex_redirect_i = ($urandom_range(0, 7) == 0); ex_redirect_pc_i = $urandom;
      mem_busy_i = ($urandom_range(0, 7) == 0);
      csr_mtvec_i = $urandom; csr_mepc_i = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
